// File: rtl/compare_arbiter_if.sv
// Request/response bundle between the requesting FSMs and the shared compare arbiter.
// Operands for requester i sit at bits [4i+3:4i] of a_bus/b_bus.
interface compare_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned PtrW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req;
   logic [4*NUM_REQ-1:0] a_bus;
   logic [4*NUM_REQ-1:0] b_bus;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   done;
   logic                 less;
   logic                 greater;
   logic                 equal;
   logic [PtrW-1:0]      rsp_id;
   logic                 busy;
   logic [CNT_W-1:0]     cmp_count;

   modport master (
      output req, a_bus, b_bus,
      input  grant, done, less, greater, equal, rsp_id, busy, cmp_count
   );

   modport slave (
      input  req, a_bus, b_bus,
      output grant, done, less, greater, equal, rsp_id, busy, cmp_count
   );
endinterface

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one 4-bit magnitude comparator between NUM_REQ requesters.
// One transaction takes three cycles: IDLE (select/latch), CMP (compare), DONE (respond).
module compare_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   compare_arbiter_if.slave  bus
);
   localparam int unsigned PtrW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

   state_e               state_q, state_d;
   logic [PtrW-1:0]      ptr_q, ptr_d;
   logic [PtrW-1:0]      idx_q, idx_d;
   logic [3:0]           opa_q, opa_d;
   logic [3:0]           opb_q, opb_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 less_q, less_d;
   logic                 greater_q, greater_d;
   logic                 equal_q, equal_d;
   logic [PtrW-1:0]      rsp_id_q, rsp_id_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 sel_found;
   logic [PtrW-1:0]      sel_idx;
   logic [PtrW-1:0]      cand;
   logic [NUM_REQ-1:0]   idx_onehot;
   logic                 cmp_lt, cmp_gt, cmp_eq;

   // First pending request at or after the pointer, wrapping at NUM_REQ-1.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
         if (!sel_found && bus.req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // The shared comparator only ever sees the latched operands.
   assign cmp_lt = opa_q < opb_q;
   assign cmp_gt = opa_q > opb_q;
   assign cmp_eq = opa_q == opb_q;

   assign idx_onehot = NUM_REQ'(1) << idx_q;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      done_d    = '0;
      less_d    = 1'b0;
      greater_d = 1'b0;
      equal_d   = 1'b0;
      rsp_id_d  = '0;
      cnt_d     = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               idx_d   = sel_idx;
               opa_d   = bus.a_bus[{sel_idx, 2'b00} +: 4];
               opb_d   = bus.b_bus[{sel_idx, 2'b00} +: 4];
               state_d = StCmp;
            end
         end
         StCmp: begin
            done_d    = idx_onehot;
            less_d    = cmp_lt;
            greater_d = cmp_gt;
            equal_d   = cmp_eq;
            rsp_id_d  = idx_q;
            ptr_d     = (idx_q == PtrW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            state_d   = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         idx_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         done_q    <= '0;
         less_q    <= 1'b0;
         greater_q <= 1'b0;
         equal_q   <= 1'b0;
         rsp_id_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         done_q    <= done_d;
         less_q    <= less_d;
         greater_q <= greater_d;
         equal_q   <= equal_d;
         rsp_id_q  <= rsp_id_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.grant     = (state_q != StIdle) ? idx_onehot : '0;
   assign bus.done      = done_q;
   assign bus.less      = less_q;
   assign bus.greater   = greater_q;
   assign bus.equal     = equal_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.cmp_count = cnt_q;
endmodule
